uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
- UART transmitter; the transmit-side counterpart of the UART receive path.
- Accepts one parallel byte per handshake and serialises it LSB-first onto tx_out as a frame: start bit, data bits, optional parity bit, one stop bit.
- Bit timing uses the same prescale convention as the receive side: each bit lasts prescale+1 clocks.
- Sits between the system-side byte source and the serial line pin.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-low reset
- p_data  input  DATA_WIDTH  byte to transmit
- data_valid  input  1  p_data valid; accepted only in IDLE
- par_en  input  1  1 = insert parity bit
- par_typ  input  1  0 = even parity, 1 = odd parity
- prescale  input  5  bit period minus one, in clocks (0..31)
- tx_out  output  1  serial line; idles high
- busy  output  1  high while a frame is in progress

Behaviour:
- Clocking and reset: single clock, rising edge. Reset is asynchronous, active-low (rst = 0).
- Reset values: tx_out = 1, busy = 0, FSM = IDLE, all counters and holding registers = 0.
- Reset mid-frame aborts the frame immediately; no partial bits resume after reset release.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - tx_out = 1, busy = 0.
  - If data_valid = 1 on a clock edge, latch p_data, par_en, par_typ and prescale, then go to START.
  - Later changes to these inputs have no effect on the frame in progress.
- Latency: tx_out drives the start bit (0) and busy rises in the first cycle after the accepting edge. Both are registered outputs.
- Bit timer:
  - A 5-bit edge counter counts 0..prescale_latched, then wraps to 0 and advances the bit index.
  - Every bit is held for exactly prescale_latched+1 clocks.
  - prescale = 0 gives 1 clock per bit.
- START: tx_out = 0 for one bit period, then DATA.
- DATA:
  - tx_out = data_latched[bit_index], bit_index 0..DATA_WIDTH-1 (LSB first).
  - After the last data bit: PARITY if par_en_latched, else STOP.
- PARITY:
  - tx_out = XOR of all data bits when par_typ = 0 (even), inverted when par_typ = 1 (odd).
  - Held for one bit period, then STOP.
- STOP:
  - tx_out = 1 for one bit period, then IDLE. busy falls in the cycle after the stop period ends.
  - IDLE lasts at least one cycle between frames; a valid held high is accepted on the first IDLE edge.
  - Consequence: back-to-back frames are separated by exactly 1 extra idle-high clock.
- Frame length: (DATA_WIDTH + 2 + par_en) × (prescale+1) clocks of busy = 1.
- data_valid while busy = 1 is ignored. There is no queue and no error flag.
- Parity is computed from the latched data, never from live p_data.
- tx_out never glitches between bits; all transitions occur on the bit-period boundary edge.

Decomposition:
- Shared package uart_pkg:
  - FSM state encoding, shared with the receive FSM style.
  - Parity type constants PAR_EVEN = 0, PAR_ODD = 1.
  - Prescale width constant (5).
- One sub-module, uart_tx_bit_timer:
  - Edge counter plus bit index, with enable and synchronous clear at frame start.
  - Outputs bit_done and bit_index.
- The FSM, data holding register and parity logic stay in uart_tx.

Test Plan:
1. Reset mid-frame: prescale = 7, send 0xA5, assert rst low after 30 cycles -> tx_out = 1 and busy = 0 in the same cycle (asynchronous); after release, line stays high with no residual bits.
2. No parity: prescale = 7, p_data = 0xA5, par_en = 0, one-cycle valid -> tx_out sequence 0,1,0,1,0,0,1,0,1,1, each bit 8 clocks; busy high for exactly 80 cycles.
3. Even and odd parity: prescale = 7, 0xA5 (popcount 4):
   - par_typ = 0 -> parity bit 0.
   - par_typ = 1 -> parity bit 1.
   - Both cases: frame 11 bits, busy 88 cycles. Repeat with 0x07 (popcount 3) -> even parity bit 1, odd parity bit 0.
4. prescale = 0, p_data = 0xFF, par_en = 1, even -> tx_out: 1 clock low, 8 clocks high, parity 0 for 1 clock, stop 1 clock high; busy 11 cycles.
5. Busy guard: during a frame, pulse data_valid with p_data = 0x3C and change prescale/par_typ -> the in-flight frame is unchanged and 0x3C is never sent.
6. Back-to-back: hold data_valid = 1 with 0x55 then 0xAA, prescale = 3 -> two complete frames separated by exactly 1 idle-high clock; second frame data bits are 0,1,0,1,0,1,0,1.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity selectors, prescale width.
package uart_pkg;

    // Bit-period prescale counter width; bit period = prescale + 1 clocks.
    localparam int unsigned PRESCALE_W = 5;

    // Parity type selectors as seen on par_typ.
    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Frame FSM states, same style as the receive FSM.
    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } uart_state_e;

endpackage

// File: rtl/uart_tx_bit_timer.sv
// Bit timer: counts clocks within a bit period and the index of the current bit.
module uart_tx_bit_timer
    import uart_pkg::*;
#(
    parameter int unsigned IdxW = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  en_i,
    input  logic                  clr_i,
    input  logic [PRESCALE_W-1:0] prescale_i,
    output logic                  bit_done_o,
    output logic [IdxW-1:0]       bit_index_o
);

    logic [PRESCALE_W-1:0] cnt_q, cnt_d;
    logic [IdxW-1:0]       idx_q, idx_d;

    // Last clock of the current bit period.
    assign bit_done_o  = en_i && (cnt_q == prescale_i);
    assign bit_index_o = idx_q;

    // Next-state: clear wins, otherwise count 0..prescale and advance the index on wrap.
    always_comb begin
        cnt_d = cnt_q;
        idx_d = idx_q;
        if (clr_i) begin
            cnt_d = '0;
            idx_d = '0;
        end else if (en_i) begin
            if (cnt_q == prescale_i) begin
                cnt_d = '0;
                idx_d = idx_q + 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: latches a byte on handshake and serialises start, data (LSB first),
// optional parity and stop bits onto tx_out with registered outputs.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] p_data,
    input  logic                  data_valid,
    input  logic                  par_en,
    input  logic                  par_typ,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  tx_out,
    output logic                  busy
);

    localparam int unsigned     IdxW    = $clog2(DATA_WIDTH + 1);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(DATA_WIDTH - 1);

    uart_state_e state_q, state_d;
    logic        tx_q, tx_d;
    logic        busy_q, busy_d;

    logic [DATA_WIDTH-1:0] data_q;
    logic                  par_en_q;
    logic                  par_typ_q;
    logic [PRESCALE_W-1:0] prescale_q;

    logic                  accept;
    logic                  timer_clr;
    logic                  timer_en;
    logic                  bit_done;
    logic [IdxW-1:0]       bit_index;
    logic                  parity;
    logic [DATA_WIDTH-1:0] data_shifted;

    assign timer_en = (state_q != StIdle);

    uart_tx_bit_timer #(
        .IdxW (IdxW)
    ) u_bit_timer (
        .clk_i       (clk),
        .rst_ni      (rst),
        .en_i        (timer_en),
        .clr_i       (timer_clr),
        .prescale_i  (prescale_q),
        .bit_done_o  (bit_done),
        .bit_index_o (bit_index)
    );

    // Parity from latched data only; odd parity inverts the even result.
    assign parity = (^data_q) ^ (par_typ_q == PAR_ODD);

    // Next data bit; the index is relative to the DATA state because the timer is
    // cleared on the START->DATA transition.
    assign data_shifted = data_q >> (bit_index + 1'b1);

    // Next-state and next registered outputs; tx_d is the value for the coming bit.
    always_comb begin
        state_d   = state_q;
        tx_d      = tx_q;
        accept    = 1'b0;
        timer_clr = 1'b0;
        unique case (state_q)
            StIdle: begin
                tx_d = 1'b1;
                if (data_valid) begin
                    accept    = 1'b1;
                    timer_clr = 1'b1;
                    state_d   = StStart;
                    tx_d      = 1'b0;
                end
            end
            StStart: begin
                if (bit_done) begin
                    timer_clr = 1'b1;
                    state_d   = StData;
                    tx_d      = data_q[0];
                end
            end
            StData: begin
                if (bit_done) begin
                    if (bit_index == LastIdx) begin
                        if (par_en_q) begin
                            state_d = StParity;
                            tx_d    = parity;
                        end else begin
                            state_d = StStop;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        tx_d = data_shifted[0];
                    end
                end
            end
            StParity: begin
                if (bit_done) begin
                    state_d = StStop;
                    tx_d    = 1'b1;
                end
            end
            StStop: begin
                if (bit_done) begin
                    state_d = StIdle;
                    tx_d    = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                tx_d    = 1'b1;
            end
        endcase
        busy_d = (state_d != StIdle);
    end

    // FSM and output registers; reset aborts any frame in progress.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
        end
    end

    // Frame operands captured on the accepting edge and held for the whole frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q     <= '0;
            par_en_q   <= 1'b0;
            par_typ_q  <= PAR_EVEN;
            prescale_q <= '0;
        end else if (accept) begin
            data_q     <= p_data;
            par_en_q   <= par_en;
            par_typ_q  <= par_typ;
            prescale_q <= prescale;
        end
    end

    assign tx_out = tx_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: a per-cycle {busy, tx_out} scoreboard is filled by a
// frame model when stimulus is driven and drained cycle by cycle against the DUT.
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] p_data;
    logic       data_valid;
    logic       par_en;
    logic       par_typ;
    logic [4:0] prescale;
    logic       tx_out;
    logic       busy;

    logic [1:0] exp_q[$];
    int         vectors     = 0;
    int         miscompares = 0;

    uart_tx #(
        .DATA_WIDTH (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .p_data     (p_data),
        .data_valid (data_valid),
        .par_en     (par_en),
        .par_typ    (par_typ),
        .prescale   (prescale),
        .tx_out     (tx_out),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Model: one {busy, tx} entry per clock of a bit period.
    task automatic push_bit(input logic b, input logic [4:0] ps);
        for (int i = 0; i <= int'(ps); i++) exp_q.push_back({1'b1, b});
    endtask

    // Model: a complete frame built from the operands as driven.
    task automatic push_frame(input logic [7:0] d, input logic pe, input logic pt,
                              input logic [4:0] ps);
        push_bit(1'b0, ps);
        for (int i = 0; i < 8; i++) push_bit(d[i], ps);
        if (pe) push_bit((^d) ^ pt, ps);
        push_bit(1'b1, ps);
    endtask

    // Drive a one-cycle valid; returns #1 after the accepting edge.
    task automatic start_frame(input logic [7:0] d, input logic pe, input logic pt,
                               input logic [4:0] ps);
        @(negedge clk);
        p_data     = d;
        par_en     = pe;
        par_typ    = pt;
        prescale   = ps;
        data_valid = 1'b1;
        @(posedge clk);
        #1;
        data_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst        = 1'b0;
        data_valid = 1'b0;
        p_data     = '0;
        par_en     = 1'b0;
        par_typ    = 1'b0;
        prescale   = '0;
        #12;
        vectors++;
        if ({busy, tx_out} !== 2'b01) begin
            miscompares++;
            $display("FAIL reset_state: busy/tx=%b expected 01", {busy, tx_out});
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({busy, tx_out} !== 2'b01) begin
            miscompares++;
            $display("FAIL reset_release_idle: busy/tx=%b expected 01", {busy, tx_out});
        end
    endtask

    task automatic test_reset_mid_frame();
        start_frame(8'hA5, 1'b0, 1'b0, 5'd7);
        repeat (30) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        vectors++;
        if ({busy, tx_out} !== 2'b01) begin
            miscompares++;
            $display("FAIL reset_mid_frame_async: busy/tx=%b expected 01", {busy, tx_out});
        end
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk);
            #1;
            vectors++;
            if ({busy, tx_out} !== 2'b01) begin
                miscompares++;
                $display("FAIL reset_no_residue cyc %0d: busy/tx=%b expected 01", c,
                         {busy, tx_out});
            end
        end
    endtask

    task automatic test_no_parity();
        logic [1:0] e;
        int         c;
        push_frame(8'hA5, 1'b0, 1'b0, 5'd7);
        start_frame(8'hA5, 1'b0, 1'b0, 5'd7);
        c = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if ({busy, tx_out} !== e) begin
                miscompares++;
                $display("FAIL no_parity cyc %0d: busy/tx=%b expected %b", c, {busy, tx_out}, e);
            end
            c++;
            @(posedge clk);
            #1;
        end
        vectors++;
        if ({busy, tx_out} !== 2'b01) begin
            miscompares++;
            $display("FAIL no_parity_end: busy/tx=%b expected 01", {busy, tx_out});
        end
    endtask

    task automatic test_parity();
        logic [7:0] dv[4] = '{8'hA5, 8'hA5, 8'h07, 8'h07};
        logic       tv[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [1:0] e;
        int         c;
        for (int k = 0; k < 4; k++) begin
            push_frame(dv[k], 1'b1, tv[k], 5'd7);
            start_frame(dv[k], 1'b1, tv[k], 5'd7);
            c = 0;
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                vectors++;
                if ({busy, tx_out} !== e) begin
                    miscompares++;
                    $display("FAIL parity d=%h typ=%0d cyc %0d: busy/tx=%b expected %b", dv[k],
                             tv[k], c, {busy, tx_out}, e);
                end
                c++;
                @(posedge clk);
                #1;
            end
            vectors++;
            if ({busy, tx_out} !== 2'b01) begin
                miscompares++;
                $display("FAIL parity_end d=%h typ=%0d: busy/tx=%b expected 01", dv[k], tv[k],
                         {busy, tx_out});
            end
            repeat (2) @(posedge clk);
            #1;
        end
    endtask

    task automatic test_prescale_zero();
        logic [1:0] e;
        int         c;
        push_frame(8'hFF, 1'b1, 1'b0, 5'd0);
        start_frame(8'hFF, 1'b1, 1'b0, 5'd0);
        c = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if ({busy, tx_out} !== e) begin
                miscompares++;
                $display("FAIL prescale0 cyc %0d: busy/tx=%b expected %b", c, {busy, tx_out}, e);
            end
            c++;
            @(posedge clk);
            #1;
        end
        vectors++;
        if ({busy, tx_out} !== 2'b01) begin
            miscompares++;
            $display("FAIL prescale0_end: busy/tx=%b expected 01", {busy, tx_out});
        end
    endtask

    task automatic test_busy_guard();
        logic [1:0] e;
        int         c;
        push_frame(8'hA5, 1'b1, 1'b0, 5'd7);
        start_frame(8'hA5, 1'b1, 1'b0, 5'd7);
        c = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if ({busy, tx_out} !== e) begin
                miscompares++;
                $display("FAIL busy_guard cyc %0d: busy/tx=%b expected %b", c, {busy, tx_out}, e);
            end
            // Disturb the live inputs mid-frame; none of this may reach the line.
            if (c == 20) begin
                p_data     = 8'h3C;
                prescale   = 5'd2;
                par_typ    = 1'b1;
                data_valid = 1'b1;
            end else if (c == 21) begin
                data_valid = 1'b0;
            end
            c++;
            @(posedge clk);
            #1;
        end
        for (int k = 0; k < 20; k++) begin
            vectors++;
            if ({busy, tx_out} !== 2'b01) begin
                miscompares++;
                $display("FAIL busy_guard_idle cyc %0d: busy/tx=%b expected 01", k,
                         {busy, tx_out});
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] e;
        int         c;
        push_frame(8'h55, 1'b0, 1'b0, 5'd3);
        exp_q.push_back(2'b01);
        push_frame(8'hAA, 1'b0, 1'b0, 5'd3);
        @(negedge clk);
        p_data     = 8'h55;
        par_en     = 1'b0;
        par_typ    = 1'b0;
        prescale   = 5'd3;
        data_valid = 1'b1;
        @(posedge clk);
        #1;
        p_data = 8'hAA;
        c = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if ({busy, tx_out} !== e) begin
                miscompares++;
                $display("FAIL back_to_back cyc %0d: busy/tx=%b expected %b", c, {busy, tx_out},
                         e);
            end
            c++;
            @(posedge clk);
            #1;
            // The edge just taken closed the idle gap and accepted the second byte.
            if (e == 2'b01) data_valid = 1'b0;
        end
        vectors++;
        if ({busy, tx_out} !== 2'b01) begin
            miscompares++;
            $display("FAIL back_to_back_end: busy/tx=%b expected 01", {busy, tx_out});
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_frame();
        test_no_parity();
        test_parity();
        test_prescale_zero();
        test_busy_guard();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
